// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and data-memory bus of the
// load/store unit, bundled so the unit and its environment share one view.
//   req_*  : execute-stage request (valid/ready, write, funct3, addr, wdata)
//   rsp_*  : one-cycle response strobe with extended load data and error
//   mem_*  : word-addressed data-memory port (lane-coded write enable,
//            read-enable code, combinational read data)
// Signal names keep the unit's original port names, so the _i/_o suffixes
// are from the unit's point of view.
// Modports: slave = the load/store unit, master = execute stage + memory.
interface load_store_unit_if #(
  parameter int WIDTH_DATA = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [2:0]            req_funct3_i;
  logic [WIDTH_DATA-1:0] req_addr_i;
  logic [WIDTH_DATA-1:0] req_wdata_i;

  logic                  rsp_valid_o;
  logic [WIDTH_DATA-1:0] rsp_rdata_o;
  logic                  rsp_error_o;

  logic [WIDTH_DATA-1:0] mem_addr_o;
  logic [WIDTH_DATA-1:0] mem_wr_data_o;
  logic [3:0]            mem_wr_enable_o;
  logic [1:0]            mem_rd_enable_o;
  logic [WIDTH_DATA-1:0] mem_rd_data_i;

  modport slave (
    input  req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i,
    input  mem_rd_data_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_error_o,
    output mem_addr_o, mem_wr_data_o, mem_wr_enable_o, mem_rd_enable_o
  );

  modport master (
    output req_valid_i, req_write_i, req_funct3_i, req_addr_i, req_wdata_i,
    output mem_rd_data_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_error_o,
    input  mem_addr_o, mem_wr_data_o, mem_wr_enable_o, mem_rd_enable_o
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the core's data-memory port.
// Takes one load/store at a time, converts the byte address and funct3 into
// a word address plus lane-coded write enable / read-enable code, and
// returns sign/zero-extended load data on a one-cycle response strobe.
// Loads that straddle a word boundary are done as two word reads; misaligned
// stores and illegal funct3 values get an error response with no access.
// Ports:
//   clock_i  rising-edge clock
//   reset_i  synchronous active-high reset; also blocks any write that
//            coincides with it
//   bus      load_store_unit_if.slave (req_*, rsp_*, mem_* signals)
module load_store_unit #(
  parameter int WIDTH_DATA = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  load_store_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACC_LO = 2'd1;
  localparam logic [1:0] S_ACC_HI = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]            state;
  logic                  wr_q;
  logic [2:0]            funct3_q;
  logic [WIDTH_DATA-1:0] addr_q;
  logic [WIDTH_DATA-1:0] wdata_q;
  logic [WIDTH_DATA-1:0] lo_q;
  logic [WIDTH_DATA-1:0] rsp_rdata_q;
  logic                  rsp_error_q;

  logic                  req_error;
  logic                  split_q;

  // Loads allow the unsigned variants; stores only B/H/W.
  function automatic logic legal_f3(input logic wr, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !wr;
      default:          return 1'b0;
    endcase
  endfunction

  // True when the access does not fit inside one word. For stores this is
  // the error condition; for loads it selects the two-read path.
  function automatic logic crosses_word(input logic [2:0] f3,
                                        input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off == 2'd3;
      2'b10:   return off != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  // Byte lane n -> 1+n, halfword at offset n -> 5+n, word -> 8.
  function automatic logic [3:0] write_code(input logic [2:0] f3,
                                            input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'd1 + {2'b00, off};
      2'b01:   return 4'd5 + {2'b00, off};
      default: return 4'b1000;
    endcase
  endfunction

  // {hi,lo} shifted so the addressed byte lands at bit 0, then trimmed and
  // extended. hi is zero for single-word loads.
  function automatic logic [31:0] load_result(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] hi,
                                              input logic [31:0] lo);
    logic [63:0] pair;
    pair = {hi, lo} >> {off, 3'b000};
    case (f3)
      F3_B:    return {{24{pair[7]}}, pair[7:0]};
      F3_H:    return {{16{pair[15]}}, pair[15:0]};
      F3_W:    return pair[31:0];
      F3_BU:   return {24'd0, pair[7:0]};
      F3_HU:   return {16'd0, pair[15:0]};
      default: return '0;
    endcase
  endfunction

  assign req_error = !legal_f3(bus.req_write_i, bus.req_funct3_i) ||
                     (bus.req_write_i &&
                      crosses_word(bus.req_funct3_i, bus.req_addr_i[1:0]));

  assign split_q = crosses_word(funct3_q, addr_q[1:0]);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      wr_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            wr_q     <= bus.req_write_i;
            funct3_q <= bus.req_funct3_i;
            addr_q   <= bus.req_addr_i;
            wdata_q  <= bus.req_wdata_i;
            if (req_error) begin
              rsp_rdata_q <= '0;
              rsp_error_q <= 1'b1;
              state       <= S_RESP;
            end else begin
              state <= S_ACC_LO;
            end
          end
        end
        S_ACC_LO: begin
          if (wr_q) begin
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            state       <= S_RESP;
          end else if (split_q) begin
            lo_q  <= bus.mem_rd_data_i;
            state <= S_ACC_HI;
          end else begin
            rsp_rdata_q <= load_result(funct3_q, addr_q[1:0], '0,
                                       bus.mem_rd_data_i);
            rsp_error_q <= 1'b0;
            state       <= S_RESP;
          end
        end
        S_ACC_HI: begin
          // The upper word is used straight off the bus rather than stored.
          rsp_rdata_q <= load_result(funct3_q, addr_q[1:0],
                                     bus.mem_rd_data_i, lo_q);
          rsp_error_q <= 1'b0;
          state       <= S_RESP;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o = (state == S_IDLE);
  assign bus.rsp_valid_o = (state == S_RESP);
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_error_o = rsp_error_q;

  always_comb begin
    bus.mem_addr_o      = '0;
    bus.mem_wr_data_o   = '0;
    bus.mem_wr_enable_o = '0;
    bus.mem_rd_enable_o = '0;
    case (state)
      S_ACC_LO: begin
        bus.mem_addr_o = {2'b00, addr_q[31:2]};
        if (wr_q) begin
          // Reset gates the write in the same cycle it is asserted.
          bus.mem_wr_enable_o = reset_i ? 4'b0000
                                        : write_code(funct3_q, addr_q[1:0]);
          bus.mem_wr_data_o   = wdata_q;
        end else begin
          bus.mem_rd_enable_o = 2'b11;
        end
      end
      S_ACC_HI: begin
        // Next word, wrapping within the 30-bit word-address space.
        bus.mem_addr_o      = {2'b00, addr_q[31:2] + 30'd1};
        bus.mem_rd_enable_o = 2'b11;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's data-memory port. Accepts one load/store request at a time from the execute stage over a valid/ready handshake. Translates the RISC-V byte address and funct3 into the data memory's word address, lane-coded write enable and read-enable code. Returns load data sign- or zero-extended to 32 bits on a single-cycle response strobe. Misaligned loads are split into two word reads; misaligned stores and illegal funct3 values are rejected with an error response and no memory access.

## Interface
- WIDTH_DATA, 32, data and address width; only 32 is supported.
- clock_i  in  1  rising-edge clock.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit idle and able to accept.
- req_write_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_error_o  out  1  misaligned store or illegal funct3; valid with rsp_valid_o.
- mem_addr_o  out  32  word address = byte address >> 2.
- mem_wr_data_o  out  32  store data, placed in low bits.
- mem_wr_enable_o  out  4  write codes:
  - byte lane 0–3 = 0001/0010/0011/0100
  - halfword at offset 0–2 = 0101/0110/0111
  - word = 1000
  - idle = 0000
- mem_rd_enable_o  out  2  always 11 (word) during a read access; 00 otherwise.
- mem_rd_data_i  in  32  combinational word read data.

## Operation
- States: IDLE, ACC_LO, ACC_HI, RESP.
- IDLE
  - req_ready_o=1.
  - On req_valid_i, latch write, funct3, addr and wdata, then decode.
  - Error (store with misaligned offset: SH at offset 3, SW at offset ≠0; or funct3 not in the legal set): go to RESP with error=1.
  - Otherwise go to ACC_LO.
- ACC_LO
  - mem_addr_o = addr[31:2].
  - Store: drive the write code from funct3 and addr[1:0]; mem_wr_data_o = wdata, low-aligned. Memory writes at the end of this cycle. Go to RESP.
  - Load: mem_rd_enable_o=11; capture mem_rd_data_i into lo.
    - Misaligned (LH/LHU at offset 3; LW at offset 1–3): go to ACC_HI.
    - Otherwise go to RESP.
- ACC_HI
  - mem_addr_o = addr[31:2]+1, wrapping modulo 2^30; mem_rd_enable_o=11.
  - Capture into hi; go to RESP.
- Load data: form {hi,lo} (hi=0 for aligned loads) >> (8·addr[1:0]), then take bits [7:0], [15:0] or [31:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- RESP: rsp_valid_o=1 for exactly one cycle, with no back-pressure; go to IDLE.
- Outside ACC_* states: mem_wr_enable_o=0000, mem_rd_enable_o=00, mem_addr_o=0, mem_wr_data_o=0.
- Reset
  - Values: state=IDLE; req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_error_o=0; all mem_* outputs 0.
  - reset_i high forces mem_wr_enable_o=0000 combinationally in the same cycle, so a store whose ACC_LO coincides with reset is not written.
  - An in-flight request is dropped with no response.

## Timing
- Handshake cycle N (req_valid_i & req_ready_o).
- Aligned access: memory access in N+1, rsp_valid_o in N+2.
- Misaligned load: reads in N+1 and N+2, rsp_valid_o in N+3.
- Error: rsp_valid_o in N+1; no memory access in any cycle.
- req_ready_o=0 from N+1 until the cycle after RESP.
- Maximum throughput: one aligned op per 3 cycles.
- Request inputs are ignored while not in IDLE.
- rsp_rdata_o and rsp_error_o hold until the next RESP.

## Test plan
- SW 0xDEADBEEF @0x10 accepted in cycle N:
  - In N+1: mem_addr_o=4, mem_wr_enable_o=1000.
  - rsp_valid_o in N+2 with error=0.
  - A following LW @0x10 returns 0xDEADBEEF.
- SB 0x000000A5 @0x13 → write code 0100 with addr 4.
  - Then LB @0x13 → 0xFFFFFFA5.
  - Then LBU @0x13 → 0x000000A5.
- Word 4 = 0x11223344, word 5 = 0x55667788:
  - LW @0x11 → 0x88112233, with reads at addr 4 then 5 and rsp at N+3.
  - LHU @0x13 → 0x00008811.
- SH @0x13, and separately funct3=011 → rsp_error_o=1 at N+1, mem_wr_enable_o=0000 in every cycle, rsp_rdata_o=0.
- Reset asserted during ACC_LO of SW @0x20 → no write (word 8 unchanged), no rsp_valid_o, req_ready_o=1 the next cycle.
- LW @0xFFFFFFFD → second read at mem_addr_o=0x00000000 (word-address wrap).
